// File: rtl/pipes_pkg.sv
// Shared pipeline types for the fetch stage: word type, fetch FSM states, PC step.
package pipes_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FETCH, DRAIN, HOLD, HALTED} fetch_state_t;
    localparam word_t PC_STEP = 32'd4;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-cache read handshake: fetch is master, cache is slave.
interface fetch_unit_if #(parameter int WORD_W = 32);
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              ihit;
    logic [WORD_W-1:0] iload;

    modport master (output iREN, iaddr, input ihit, iload);
    modport slave  (input iREN, iaddr, output ihit, iload);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads the icache, and feeds IF/ID with a one-entry stall buffer.
module fetch_unit
    import pipes_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    fetch_unit_if.master      icache,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [WORD_W-1:0] instr_o,
    output logic [WORD_W-1:0] npc_o,
    output logic              valid_o,
    output logic [31:0]       fetch_cnt
);
    fetch_state_t      state, state_n;
    logic [WORD_W-1:0] pc, pc_n, pend_pc, pend_pc_n;
    logic [WORD_W-1:0] buf_instr, buf_instr_n, buf_npc, buf_npc_n;
    logic [WORD_W-1:0] pc_inc;

    assign pc_inc       = pc + WORD_W'(PC_STEP);
    // Address tracks pc, which only moves on a hit, so it is stable while a request waits.
    assign icache.iaddr = pc;

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pend_pc_n   = pend_pc;
        buf_instr_n = buf_instr;
        buf_npc_n   = buf_npc;
        icache.iREN = 1'b0;
        valid_o     = 1'b0;
        instr_o     = '0;
        npc_o       = '0;
        case (state)
            FETCH: begin
                icache.iREN = 1'b1;
                if (halt) begin
                    state_n = HALTED;
                end else if (redirect) begin
                    if (icache.ihit) begin
                        pc_n = redirect_pc;
                    end else begin
                        pend_pc_n = redirect_pc;
                        state_n   = DRAIN;
                    end
                end else if (icache.ihit) begin
                    pc_n = pc_inc;
                    if (stall) begin
                        buf_instr_n = icache.iload;
                        buf_npc_n   = pc_inc;
                        state_n     = HOLD;
                    end else begin
                        valid_o = 1'b1;
                        instr_o = icache.iload;
                        npc_o   = pc_inc;
                    end
                end
            end
            DRAIN: begin
                // The stale request must complete before the new PC may be presented.
                icache.iREN = 1'b1;
                if (halt) begin
                    state_n = HALTED;
                end else if (icache.ihit) begin
                    pc_n    = redirect ? redirect_pc : pend_pc;
                    state_n = FETCH;
                end else if (redirect) begin
                    pend_pc_n = redirect_pc;
                end
            end
            HOLD: begin
                instr_o = buf_instr;
                npc_o   = buf_npc;
                if (halt) begin
                    state_n = HALTED;
                end else if (redirect) begin
                    pc_n    = redirect_pc;
                    state_n = FETCH;
                end else if (!stall) begin
                    valid_o = 1'b1;
                    state_n = FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= FETCH;
            pc        <= WORD_W'(PC_INIT);
            pend_pc   <= '0;
            buf_instr <= '0;
            buf_npc   <= '0;
            fetch_cnt <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            pend_pc   <= pend_pc_n;
            buf_instr <= buf_instr_n;
            buf_npc   <= buf_npc_n;
            fetch_cnt <= fetch_cnt + {31'd0, valid_o};
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios followed by randomized traffic.
module tb_fetch_unit;
    import pipes_pkg::*;
    localparam logic [31:0] PC_INIT = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        stall = 1'b0, redirect = 1'b0, halt = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr_o, npc_o, fetch_cnt;
    logic        valid_o;

    fetch_unit_if #(.WORD_W(32)) ic ();

    fetch_unit #(.PC_INIT(PC_INIT), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .icache(ic), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .instr_o(instr_o), .npc_o(npc_o),
        .valid_o(valid_o), .fetch_cnt(fetch_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        ren;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ins;
        logic [31:0] npc;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;

    // Reference model: a PC, a queue holding a redirect target while a stale
    // request drains, a queue holding an instruction parked by a stall.
    logic [31:0] m_pc, m_cnt;
    bit          m_halted;
    logic [31:0] m_pend[$];
    logic [63:0] m_held[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    exp_t mon_e;
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("iREN", {31'd0, ic.iREN}, {31'd0, mon_e.ren});
            chk("iaddr", ic.iaddr, mon_e.addr);
            chk("valid_o", {31'd0, valid_o}, {31'd0, mon_e.vld});
            chk("instr_o", instr_o, mon_e.ins);
            chk("npc_o", npc_o, mon_e.npc);
            chk("fetch_cnt", fetch_cnt, mon_e.cnt);
            if (valid_o && stall) begin
                errors++;
                $display("FAIL valid_with_stall at %0t", $time);
            end
        end
    end

    function automatic bit m_ren();
        return !m_halted && m_held.size() == 0;
    endfunction

    // Called at posedge+1: apply inputs, predict this cycle's outputs, then advance the model.
    task automatic step(input logic h, input logic [31:0] ld, input logic st,
                        input logic rd, input logic [31:0] rp, input logic hl);
        exp_t e;
        ic.ihit = h; ic.iload = ld; stall = st; redirect = rd; redirect_pc = rp; halt = hl;
        e = '0;
        e.addr = m_pc;
        e.cnt  = m_cnt;
        if (!m_halted) begin
            if (m_held.size() > 0) begin
                e.ins = m_held[0][63:32];
                e.npc = m_held[0][31:0];
                e.vld = !st && !rd && !hl;
            end else begin
                e.ren = 1'b1;
                if (!hl && !rd && m_pend.size() == 0 && h && !st) begin
                    e.vld = 1'b1;
                    e.ins = ld;
                    e.npc = m_pc + 32'd4;
                end
            end
        end
        sb.push_back(e);
        @(posedge CLK);
        if (m_halted) begin
        end else if (hl) begin
            m_halted = 1'b1;
            m_pend.delete();
            m_held.delete();
        end else if (m_held.size() > 0) begin
            if (rd) m_pc = rp;
            if (rd || !st) m_held.delete();
        end else if (m_pend.size() > 0) begin
            if (h) begin
                m_pc = rd ? rp : m_pend[0];
                m_pend.delete();
            end else if (rd) begin
                m_pend[0] = rp;
            end
        end else if (rd) begin
            if (h) m_pc = rp;
            else m_pend.push_back(rp);
        end else if (h) begin
            if (st) m_held.push_back({ld, m_pc + 32'd4});
            m_pc = m_pc + 32'd4;
        end
        m_cnt = m_cnt + {31'd0, e.vld};
        #1;
    endtask

    task automatic do_reset();
        exp_t e;
        nRST = 1'b0;
        ic.ihit = 1'b0; ic.iload = '0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        m_pc = PC_INIT; m_cnt = '0; m_halted = 1'b0;
        m_pend.delete(); m_held.delete();
        e = '0; e.ren = 1'b1; e.addr = PC_INIT;
        sb.push_back(e);
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    initial begin
        logic h, st, rd, hl;
        logic [31:0] rp;
        int halted_cycles;
        ic.ihit = 1'b0; ic.iload = '0;
        @(posedge CLK); #1;
        do_reset();
        // Streaming hits, then stall capture at pc=0x10
        for (int i = 1; i <= 4; i++) step(1, 32'h2000_0000 + i, 0, 0, 0, 0);
        step(1, 32'hDEAD_BEEF, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 32'h1234_5678, 0, 0, 0, 0);
        // Redirect while a request is outstanding
        step(1, 32'h0BAD_0001, 0, 1, 32'h20, 0);
        step(0, 0, 0, 1, 32'h100, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 32'h0BAD_0002, 0, 0, 0, 0);
        step(1, 32'h3000_0000, 0, 0, 0, 0);
        // Hit with redirect, then double redirect in DRAIN
        step(1, 32'h0BAD_0003, 0, 1, 32'h40, 0);
        step(0, 0, 0, 1, 32'h80, 0);
        step(0, 0, 0, 1, 32'hC0, 0);
        step(1, 32'h0BAD_0004, 0, 0, 0, 0);
        step(1, 32'h4000_0000, 0, 0, 0, 0);
        // Wrap past the top of the address space
        step(1, 32'h0BAD_0005, 0, 1, 32'hFFFF_FFFC, 0);
        step(1, 32'h5000_0000, 0, 0, 0, 0);
        step(1, 32'h5000_0001, 0, 0, 0, 0);
        // Halt beats redirect and hit; then asynchronous reset out of HALTED
        step(1, 32'h0BAD_0006, 0, 1, 32'h500, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        #2 nRST = 1'b0;
        #1;
        chk("reset_iREN", {31'd0, ic.iREN}, 32'd1);
        chk("reset_iaddr", ic.iaddr, PC_INIT);
        chk("reset_cnt", fetch_cnt, 32'd0);
        @(posedge CLK); #1;
        do_reset();

        halted_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            h  = m_ren() ? ($urandom_range(0, 2) != 0) : 1'b0;
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 9) == 0);
            rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            hl = ($urandom_range(0, 99) == 0);
            step(h, $urandom, st, rd, rp, hl);
            if (m_halted) halted_cycles++;
            if (halted_cycles > 3) begin
                halted_cycles = 0;
                do_reset();
            end
        end

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of the IF/ID pipeline register. Owns the PC and issues word reads to the instruction cache over a request/hit handshake. Delivers instruction plus PC+4 to IF/ID with a per-cycle enable. Handles downstream stalls through a one-entry hold buffer, branch/jump redirects (including redirects that arrive while a request is outstanding), and a sticky halt.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
WORD_W, 32, instruction/address width

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
iREN  out  1  icache read request
iaddr  out  WORD_W  icache read address
ihit  in  1  icache response valid this cycle
iload  in  WORD_W  icache read data, valid when ihit
stall  in  1  IF/ID cannot accept this cycle
redirect  in  1  load new PC (branch/jump resolved)
redirect_pc  in  WORD_W  target PC, valid with redirect
halt  in  1  halt retired; stop fetching
instr_o  out  WORD_W  instruction to IF/ID instr_i
npc_o  out  WORD_W  PC+4 of that instruction, to IF/ID npc_i
valid_o  out  1  drives IF/ID EN; asserted only when delivery is accepted (never with stall=1)
fetch_cnt  out  32  instructions delivered since reset

Behaviour:
- Reset, asynchronous: pc=PC_INIT, state=FETCH, hold buffer and pend_pc = 0, fetch_cnt=0. Combinational outputs from reset state: iREN=1, iaddr=PC_INIT, valid_o=0, instr_o=0, npc_o=0.
- iaddr = pc. It stays stable while iREN=1 and ihit=0; the cache requires this.
- iload is used in the same cycle as ihit. Zero added latency: the delivery cycle equals the ihit cycle.
- Priority within every state: halt > redirect > ihit/stall.
- FETCH: iREN=1.
  - ihit & redirect: discard data; pc<=redirect_pc; stay in FETCH.
  - ihit & stall: buf_instr<=iload; buf_npc<=pc+4; pc<=pc+4; go to HOLD.
  - ihit otherwise: valid_o=1, instr_o=iload, npc_o=pc+4; pc<=pc+4.
  - redirect & !ihit: pend_pc<=redirect_pc; go to DRAIN. pc is unchanged so iaddr stays stable.
- DRAIN: iREN=1, iaddr=old pc, valid_o=0.
  - Another redirect overwrites pend_pc; if it arrives with ihit, redirect_pc wins directly.
  - ihit: discard data; pc<=pend_pc (or redirect_pc if redirect is high that cycle); go to FETCH.
- HOLD: iREN=0; instr_o=buf_instr, npc_o=buf_npc.
  - valid_o = !stall. When !stall, go to FETCH.
  - redirect: drop the buffer; pc<=redirect_pc; go to FETCH; valid_o=0.
- HALTED: iREN=0, valid_o=0, instr_o=0, npc_o=0.
  - Sticky; exits only on reset.
  - halt in any state goes to HALTED next cycle, abandoning any outstanding request; ihit and redirect that cycle are ignored and valid_o=0.
- Outputs: instr_o and npc_o are 0 whenever valid_o=0, except in HOLD, where they show the buffer.
- PC arithmetic: pc+4 is modulo 2^WORD_W; 32'hFFFF_FFFC wraps to 0. No alignment check; redirect_pc[1:0] is passed through unchanged.
- fetch_cnt increments on every cycle with valid_o=1 and wraps at 2^32.
- valid_o must never be 1 while stall=1.

Decomposition:
- Shared package pipes_pkg holds:
  - word_t (logic [31:0])
  - fetch_state_t enum {FETCH, DRAIN, HOLD, HALTED}
  - constant PC_STEP = 4
- IF/ID interface signals connect by name to instr_i/npc_i/EN.
- No sub-module: the single module is one state register plus pc/pend_pc/buffer/counter registers and next-state logic.

Test Plan:
- Reset and stream: release nRST with PC_INIT=0, ihit=1 every cycle, iload=0x2000_0001, 0x2000_0002, ... -> iaddr 0,4,8; valid_o=1 each cycle; npc_o 4,8,12; fetch_cnt=3 after three cycles.
- Stall capture: ihit=1 with iload=0xDEAD_BEEF and stall=1 at pc=0x10, then stall held 2 cycles -> state HOLD; iREN=0; valid_o=0 for those cycles. On the first stall=0 cycle: valid_o=1, instr_o=0xDEAD_BEEF, npc_o=0x14. The next request has iaddr=0x14.
- Redirect mid-request: pc=0x20, ihit=0, redirect=1 with redirect_pc=0x100, then ihit after 3 cycles -> iaddr holds 0x20 through DRAIN; the returned data is not delivered (valid_o=0). The next iaddr is 0x100.
- Redirect with hit and double redirect in DRAIN: (a) ihit & redirect to 0x40 in FETCH -> no delivery; next iaddr=0x40. (b) In DRAIN, redirect to 0x80 then to 0xC0 before ihit -> fetch resumes at 0xC0.
- Halt priority: halt=1 together with ihit=1 and redirect=1 -> valid_o=0; iREN=0 from the next cycle onward; fetch_cnt frozen. Reset mid-HALTED -> iaddr=PC_INIT and iREN=1 immediately.
- Wrap: redirect to 0xFFFF_FFFC, ihit -> npc_o=0x0000_0000; next iaddr=0.
